// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS control pipeline: opcode fields, ALU/branch/memory codes,
// exception codes, the per-stage control bundle and the trap sequencer states.
package ctrl_pkg;

  localparam int CTRL_ALUOP_W = 5;
  localparam int CTRL_EXC_W   = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_ERET    = 6'h18;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [4:0] RS_MF = 5'h00;
  localparam logic [4:0] RS_MT = 5'h04;
  localparam logic [4:0] RS_CO = 5'h10;

  // MFC0/MTC0 ride through the ALU field so the datapath can steer CP0 traffic
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADDU = 5'd1;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SUBU = 5'd3;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_AND  = 5'd4;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OR   = 5'd5;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_XOR  = 5'd6;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_NOR  = 5'd7;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLL  = 5'd10;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRL  = 5'd11;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRA  = 5'd12;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLLV = 5'd13;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRLV = 5'd14;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRAV = 5'd15;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_LUI  = 5'd16;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_MFC0 = 5'd17;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_MTC0 = 5'd18;

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_BEQ    = 4'd1;
  localparam logic [3:0] BR_BNE    = 4'd2;
  localparam logic [3:0] BR_BGTZ   = 4'd3;
  localparam logic [3:0] BR_BLEZ   = 4'd4;
  localparam logic [3:0] BR_BGEZ   = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZAL = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;

  localparam logic [2:0] MR_LB  = 3'd1;
  localparam logic [2:0] MR_LBU = 3'd2;
  localparam logic [2:0] MR_LH  = 3'd3;
  localparam logic [2:0] MR_LHU = 3'd4;
  localparam logic [2:0] MR_LW  = 3'd5;

  localparam logic [1:0] MW_SB = 2'd1;
  localparam logic [1:0] MW_SH = 2'd2;
  localparam logic [1:0] MW_SW = 2'd3;

  // RegDst: destination register is rt, rd or $31; DataDst selects the PC+8 link value
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [CTRL_EXC_W-1:0] EXC_NOT     = 5'd0;
  localparam logic [CTRL_EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [CTRL_EXC_W-1:0] EXC_BREAK   = 5'd9;
  localparam logic [CTRL_EXC_W-1:0] EXC_RI      = 5'd10;

  typedef struct packed {
    logic [1:0]              reg_dst;
    logic                    jump;
    logic [3:0]              branch;
    logic [2:0]              mem_read;
    logic                    mem_to_reg;
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic [1:0]              mem_write;
    logic                    alu_src;
    logic                    reg_write;
    logic                    ext_op;
    logic                    data_dst;
    logic                    jr;
    logic [CTRL_EXC_W-1:0]   exccode;
    logic                    eret;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_RET} state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder; anything unrecognised yields an RI exception
// bundle with every write and memory field cleared.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       r_alu;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[15:6];

  always_comb begin
    ctrl  = '0;
    r_alu = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_ADD:  begin r_alu = 1'b1; ctrl.alu_op = ALU_ADD;  end
          F_ADDU: begin r_alu = 1'b1; ctrl.alu_op = ALU_ADDU; end
          F_SUB:  begin r_alu = 1'b1; ctrl.alu_op = ALU_SUB;  end
          F_SUBU: begin r_alu = 1'b1; ctrl.alu_op = ALU_SUBU; end
          F_AND:  begin r_alu = 1'b1; ctrl.alu_op = ALU_AND;  end
          F_OR:   begin r_alu = 1'b1; ctrl.alu_op = ALU_OR;   end
          F_XOR:  begin r_alu = 1'b1; ctrl.alu_op = ALU_XOR;  end
          F_NOR:  begin r_alu = 1'b1; ctrl.alu_op = ALU_NOR;  end
          F_SLT:  begin r_alu = 1'b1; ctrl.alu_op = ALU_SLT;  end
          F_SLTU: begin r_alu = 1'b1; ctrl.alu_op = ALU_SLTU; end
          F_SLL:  begin r_alu = 1'b1; ctrl.alu_op = ALU_SLL;  end
          F_SRL:  begin r_alu = 1'b1; ctrl.alu_op = ALU_SRL;  end
          F_SRA:  begin r_alu = 1'b1; ctrl.alu_op = ALU_SRA;  end
          F_SLLV: begin r_alu = 1'b1; ctrl.alu_op = ALU_SLLV; end
          F_SRLV: begin r_alu = 1'b1; ctrl.alu_op = ALU_SRLV; end
          F_SRAV: begin r_alu = 1'b1; ctrl.alu_op = ALU_SRAV; end
          F_JR:   ctrl.jr = 1'b1;
          F_JALR: begin
            ctrl.jr        = 1'b1;
            ctrl.reg_dst   = RD_RD;
            ctrl.reg_write = 1'b1;
            ctrl.data_dst  = 1'b1;
          end
          F_SYSCALL: ctrl.exccode = EXC_SYSCALL;
          F_BREAK:   ctrl.exccode = EXC_BREAK;
          default:   ctrl.exccode = EXC_RI;
        endcase
        if (r_alu) begin
          ctrl.reg_dst   = RD_RD;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU);
        case (op)
          OP_ADDI:  ctrl.alu_op = ALU_ADD;
          OP_ADDIU: ctrl.alu_op = ALU_ADDU;
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          OP_SLTIU: ctrl.alu_op = ALU_SLTU;
          OP_ANDI:  ctrl.alu_op = ALU_AND;
          OP_ORI:   ctrl.alu_op = ALU_OR;
          OP_XORI:  ctrl.alu_op = ALU_XOR;
          default:  ctrl.alu_op = ALU_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.alu_src    = 1'b1;
        ctrl.ext_op     = 1'b1;
        ctrl.alu_op     = ALU_ADDU;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        case (op)
          OP_LB:   ctrl.mem_read = MR_LB;
          OP_LBU:  ctrl.mem_read = MR_LBU;
          OP_LH:   ctrl.mem_read = MR_LH;
          OP_LHU:  ctrl.mem_read = MR_LHU;
          default: ctrl.mem_read = MR_LW;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALU_ADDU;
        ctrl.mem_write = (op == OP_SB) ? MW_SB : (op == OP_SH) ? MW_SH : MW_SW;
      end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: begin
        ctrl.ext_op = 1'b1;
        ctrl.alu_op = ALU_SUBU;
        case (op)
          OP_BEQ:  ctrl.branch = BR_BEQ;
          OP_BNE:  ctrl.branch = BR_BNE;
          OP_BGTZ: ctrl.branch = BR_BGTZ;
          default: ctrl.branch = BR_BLEZ;
        endcase
      end
      OP_REGIMM: begin
        ctrl.ext_op = 1'b1;
        ctrl.alu_op = ALU_SUBU;
        case (rt)
          RT_BGEZ: ctrl.branch = BR_BGEZ;
          RT_BLTZ: ctrl.branch = BR_BLTZ;
          RT_BGEZAL, RT_BLTZAL: begin
            ctrl.branch    = (rt == RT_BGEZAL) ? BR_BGEZAL : BR_BLTZAL;
            ctrl.reg_dst   = RD_RA;
            ctrl.reg_write = 1'b1;
            ctrl.data_dst  = 1'b1;
          end
          default: begin
            ctrl         = '0;
            ctrl.exccode = EXC_RI;
          end
        endcase
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_dst   = RD_RA;
        ctrl.reg_write = 1'b1;
        ctrl.data_dst  = 1'b1;
      end
      OP_COP0: begin
        if (rs == RS_MF) begin
          ctrl.alu_op    = ALU_MFC0;
          ctrl.reg_write = 1'b1;
        end else if (rs == RS_MT) begin
          ctrl.alu_op = ALU_MTC0;
        end else if (rs == RS_CO && funct == F_ERET) begin
          ctrl.eret = 1'b1;
        end else begin
          ctrl.exccode = EXC_RI;
        end
      end
      default: ctrl.exccode = EXC_RI;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control bundle pipeline ID->EX->MEM->WB (one stage per cycle; stall holds every stage)
// plus precise SYSCALL/BREAK/RI/ERET sequencing with a one-cycle PC redirect.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               ALUOP_W    = 5,
  parameter int               EXCCODE_W  = 5,
  parameter int               N_STAGE    = 3,
  parameter logic [XLEN-1:0]  EXC_VECTOR = 32'h8000_0180
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 id_instr,
  input  logic [XLEN-1:0]             id_pc,
  input  logic                        id_valid,
  input  logic                        stall,
  input  logic                        flush_id,
  output logic [N_STAGE*CTRL_W-1:0]   stg_ctrl,
  output logic [N_STAGE-1:0]          stg_valid,
  output logic                        redirect,
  output logic [XLEN-1:0]             redirect_pc,
  output logic [XLEN-1:0]             epc,
  output logic [EXCCODE_W-1:0]        cause_code,
  output logic                        exl
);

  if (ALUOP_W != CTRL_ALUOP_W) begin : g_bad_aluop_w
    $error("ctrl_pipe: ALUOP_W must equal ctrl_pkg::CTRL_ALUOP_W");
  end
  if (EXCCODE_W != CTRL_EXC_W) begin : g_bad_exc_w
    $error("ctrl_pipe: EXCCODE_W must equal ctrl_pkg::CTRL_EXC_W");
  end
  if (N_STAGE < 2 || N_STAGE > 4) begin : g_bad_n_stage
    $error("ctrl_pipe: N_STAGE must be 2..4");
  end

  ctrl_t [N_STAGE-1:0]   stg_q, stg_d;
  logic  [N_STAGE-1:0]   vld_q, vld_d;
  logic  [XLEN-1:0]      ex_pc_q, ex_pc_d;
  logic  [XLEN-1:0]      epc_q, epc_d;
  logic  [CTRL_EXC_W-1:0] cause_q, cause_d;
  logic                  exl_q, exl_d;
  state_t                state_q, state_d;

  ctrl_t id_ctrl;
  ctrl_t ex;
  logic  trap_det;
  logic  eret_det;

  ctrl_decode u_decode (
    .instr (id_instr),
    .ctrl  (id_ctrl)
  );

  // Detection is frozen while stalled so a held EX bundle cannot trap twice
  always_comb begin
    ex       = stg_q[0];
    trap_det = (state_q == ST_RUN) && !stall && vld_q[0] && (ex.exccode != EXC_NOT);
    eret_det = (state_q == ST_RUN) && !stall && vld_q[0] && (ex.exccode == EXC_NOT) && ex.eret;
  end

  always_comb begin
    stg_d   = stg_q;
    vld_d   = vld_q;
    ex_pc_d = ex_pc_q;
    if (trap_det || eret_det) begin
      for (int i = N_STAGE - 1; i >= 2; i--) begin
        stg_d[i] = stg_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
      stg_d[1] = '0;
      vld_d[1] = 1'b0;
      stg_d[0] = '0;
      vld_d[0] = 1'b0;
    end else if (!stall) begin
      for (int i = N_STAGE - 1; i >= 1; i--) begin
        stg_d[i] = stg_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
      // The ID slot seen during a redirect cycle is wrong-path, so it never enters EX
      if (flush_id || !id_valid || state_q != ST_RUN) begin
        stg_d[0] = '0;
        vld_d[0] = 1'b0;
      end else begin
        stg_d[0] = id_ctrl;
        vld_d[0] = 1'b1;
        ex_pc_d  = id_pc;
      end
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    epc_d       = epc_q;
    cause_d     = cause_q;
    exl_d       = exl_q;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      ST_RUN: begin
        if (trap_det) begin
          state_d = ST_TRAP;
          cause_d = ex.exccode;
          if (!exl_q) begin
            epc_d = ex_pc_q;
            exl_d = 1'b1;
          end
        end else if (eret_det) begin
          state_d = ST_RET;
          exl_d   = 1'b0;
        end
      end
      ST_TRAP: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VECTOR;
      end
      ST_RET: begin
        redirect    = 1'b1;
        redirect_pc = epc_q;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q   <= '0;
      vld_q   <= '0;
      ex_pc_q <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      stg_q   <= stg_d;
      vld_q   <= vld_d;
      ex_pc_q <= ex_pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      state_q <= state_d;
    end
  end

  assign stg_ctrl   = stg_q;
  assign stg_valid  = vld_q;
  assign epc        = epc_q;
  assign cause_code = EXCCODE_W'(cause_q);
  assign exl        = exl_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode, pipeline advance, stall/flush, trap/ERET sequencing, async reset.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [31:0]           id_instr;
  logic [31:0]           id_pc;
  logic                  id_valid;
  logic                  stall;
  logic                  flush_id;
  logic [3*CTRL_W-1:0]   stg_ctrl;
  logic [2:0]            stg_valid;
  logic                  redirect;
  logic [31:0]           redirect_pc;
  logic [31:0]           epc;
  logic [4:0]            cause_code;
  logic                  exl;

  ctrl_t ex_c, mem_c, wb_c;
  assign ex_c  = stg_ctrl[CTRL_W-1:0];
  assign mem_c = stg_ctrl[2*CTRL_W-1:CTRL_W];
  assign wb_c  = stg_ctrl[3*CTRL_W-1:2*CTRL_W];

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_pipe #(
    .XLEN       (32),
    .ALUOP_W    (5),
    .EXCCODE_W  (5),
    .N_STAGE    (3),
    .EXC_VECTOR (32'h8000_0180)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .stall       (stall),
    .flush_id    (flush_id),
    .stg_ctrl    (stg_ctrl),
    .stg_valid   (stg_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .cause_code  (cause_code),
    .exl         (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic vld);
    id_instr = instr;
    id_pc    = pc;
    id_valid = vld;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush_id = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    step();
    step();
    chk("rst_stg_ctrl",    stg_ctrl, 0);
    chk("rst_stg_valid",   stg_valid, 0);
    chk("rst_epc",         epc, 0);
    chk("rst_cause",       cause_code, 0);
    chk("rst_exl",         exl, 0);
    chk("rst_redirect",    redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    rst_n = 1'b1;
    step();

    // ADDU $2,$4,$5 flows EX -> MEM -> WB
    drive(32'h0085_1021, 32'h100, 1'b1);
    step();
    chk("addu_ex_valid",   stg_valid, 3'b001);
    chk("addu_regdst",     ex_c.reg_dst, 2'b01);
    chk("addu_regwrite",   ex_c.reg_write, 1);
    chk("addu_aluop",      ex_c.alu_op, 1);
    chk("addu_memwrite",   ex_c.mem_write, 0);
    drive(32'h0, 32'h0, 1'b0);
    step();
    chk("addu_mem_valid",  stg_valid, 3'b010);
    step();
    chk("addu_wb_valid",   stg_valid, 3'b100);
    chk("addu_wb_regwr",   wb_c.reg_write, 1);
    chk("addu_wb_regdst",  wb_c.reg_dst, 2'b01);

    // SYSCALL at 0x400, followed by an ADDU that must be squashed
    drive(32'h0000_000C, 32'h400, 1'b1);
    step();
    chk("sys_ex_code",     ex_c.exccode, 8);
    chk("sys_ex_regwrite", ex_c.reg_write, 0);
    chk("sys_no_redirect", redirect, 0);
    drive(32'h0085_1021, 32'h404, 1'b1);
    step();
    chk("sys_redirect",    redirect, 1);
    chk("sys_redirect_pc", redirect_pc, 32'h8000_0180);
    chk("sys_epc",         epc, 32'h400);
    chk("sys_cause",       cause_code, 8);
    chk("sys_exl",         exl, 1);
    chk("sys_ex_invalid",  stg_valid[0], 0);
    chk("sys_mem_invalid", stg_valid[1], 0);
    drive(32'h0, 32'h0, 1'b0);
    step();
    chk("sys_redirect_1cyc", redirect, 0);

    // BREAK at 0x500 while exl=1: epc holds
    drive(32'h0000_000D, 32'h500, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0);
    step();
    chk("brk_redirect",    redirect, 1);
    chk("brk_redirect_pc", redirect_pc, 32'h8000_0180);
    chk("brk_epc_kept",    epc, 32'h400);
    chk("brk_cause",       cause_code, 9);
    chk("brk_exl",         exl, 1);
    step();

    // ERET returns to epc and clears exl
    drive(32'h4200_0018, 32'h700, 1'b1);
    step();
    chk("eret_ex_flag",    ex_c.eret, 1);
    chk("eret_ex_code",    ex_c.exccode, 0);
    drive(32'h0, 32'h0, 1'b0);
    step();
    chk("eret_redirect",    redirect, 1);
    chk("eret_redirect_pc", redirect_pc, 32'h400);
    chk("eret_exl",         exl, 0);
    chk("eret_epc",         epc, 32'h400);
    step();
    chk("eret_redirect_1cyc", redirect, 0);
    step();

    // ORI then LW; hold three cycles (last one with flush_id too), then flush on release
    drive(32'h34A5_0001, 32'h800, 1'b1);
    step();
    drive(32'h8C88_0004, 32'h804, 1'b1);
    step();
    chk("lw_ex_memread", ex_c.mem_read, 5);
    stall = 1'b1;
    drive(32'hAC88_0008, 32'h808, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) flush_id = 1'b1;
      step();
      chk("stall_valid",    stg_valid, 3'b011);
      chk("stall_ex_mr",    ex_c.mem_read, 5);
      chk("stall_ex_m2r",   ex_c.mem_to_reg, 1);
      chk("stall_mem_alu",  mem_c.alu_op, 5);
      chk("stall_mem_src",  mem_c.alu_src, 1);
    end
    stall = 1'b0;
    step();
    chk("flush_valid",     stg_valid, 3'b110);
    chk("flush_ex_bubble", ex_c, 0);
    chk("flush_mem_lw",    mem_c.mem_read, 5);
    chk("flush_wb_ori",    wb_c.alu_op, 5);
    flush_id = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    step();
    step();

    // Opcode 0x3F -> RI; trap overrides a simultaneous flush_id; then async reset in TRAP
    drive(32'hFC00_0000, 32'h600, 1'b1);
    step();
    chk("ri_ex_code",     ex_c.exccode, 10);
    chk("ri_ex_regwrite", ex_c.reg_write, 0);
    chk("ri_ex_memread",  ex_c.mem_read, 0);
    flush_id = 1'b1;
    drive(32'h0085_1021, 32'h604, 1'b1);
    step();
    chk("ri_redirect",    redirect, 1);
    chk("ri_redirect_pc", redirect_pc, 32'h8000_0180);
    chk("ri_cause",       cause_code, 10);
    chk("ri_epc",         epc, 32'h600);
    chk("ri_exl",         exl, 1);
    flush_id = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_redirect",    redirect, 0);
    chk("arst_redirect_pc", redirect_pc, 0);
    chk("arst_epc",         epc, 0);
    chk("arst_cause",       cause_code, 0);
    chk("arst_exl",         exl, 0);
    chk("arst_valid",       stg_valid, 0);
    chk("arst_ctrl",        stg_ctrl, 0);
    step();
    rst_n = 1'b1;
    step();

    // First instruction after reset decodes normally
    drive(32'h0085_1021, 32'h900, 1'b1);
    step();
    chk("post_rst_valid", stg_valid, 3'b001);
    chk("post_rst_regwr", ex_c.reg_write, 1);
    drive(32'h0, 32'h0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the five-stage MIPS core. It decodes the ID-stage instruction into a control bundle and carries that bundle through EX, MEM and WB, honouring stall and flush requests. It also owns precise exception sequencing for SYSCALL, BREAK, undefined instructions and ERET: it maintains EPC, cause and EXL, and produces a single-cycle PC redirect. It sits between the IF/ID register and the datapath stage registers, and replaces the purely combinational decoder.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width.
- `ALUOP_W`, 5, ALUOp field width.
- `EXCCODE_W`, 5, exception code width.
- `N_STAGE`, 3, number of registered control stages after ID (EX, MEM, WB); legal range 2–4.
- `EXC_VECTOR`, 32'h8000_0180, trap handler address.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_instr` in 32: instruction in ID.
- `id_pc` in XLEN: PC of the ID instruction.
- `id_valid` in 1: the ID slot holds a real instruction.
- `stall` in 1: hazard unit hold; freezes all stage registers.
- `flush_id` in 1: branch/jump squash; bubble enters EX.
- `stg_ctrl` out N_STAGE×CTRL_W: packed control bundles, index 0 = EX.
- `stg_valid` out N_STAGE: per-stage valid.
- `redirect` out 1: PC override strobe.
- `redirect_pc` out XLEN: override target.
- `epc` out XLEN: exception PC.
- `cause_code` out EXCCODE_W: last exception code.
- `exl` out 1: exception level.

## Operation
- Bundle fields, in packed order: RegDst[1:0], Jump, Branch[3:0], MemRead[2:0], MemtoReg, ALUOp, MemWrite[1:0], ALUSrc, RegWrite, ExtOp, DataDst, JR, EXCCODE, ERET. CTRL_W is derived from these fields.
- Decode covers the R-type ALU set, JR/JALR, I-type ALU ops, loads and stores (b/h/w), BEQ/BNE/BGTZ/BLEZ, REGIMM BGEZ/BLTZ/BGEZAL/BLTZAL, J/JAL, MFC0/MTC0/ERET.
  - Unknown opcode/funct, or an unknown REGIMM rt: EXCCODE = RI (10), with all write/mem fields cleared.
  - SYSCALL: code 8. BREAK: code 9.
  - An exception bundle has RegWrite = 0 and MemWrite = 0.
- A bubble is an all-zero bundle with valid = 0.
- The FSM has three states: RUN, TRAP, RET.
  - RUN→TRAP: when stg_valid[0] is set and EX EXCCODE ≠ 0.
  - RUN→RET: when stg_valid[0] is set and EX ERET = 1, with no exception pending.
  - TRAP→RUN and RET→RUN: unconditional after one cycle.
- Entering TRAP:
  - If exl = 0: epc ← EX pc and exl ← 1.
  - If exl = 1: epc is unchanged.
  - cause_code ← the EX code, always.
- Entering RET: exl ← 0.
- TRAP/RET entry squashes EX and bubbles the incoming ID instruction. MEM and WB proceed, so older instructions retire.
- In TRAP: redirect = 1, redirect_pc = EXC_VECTOR.
- In RET: redirect = 1, redirect_pc = epc (the value before any update).

## Timing
- Reset values: every stg_ctrl and stg_valid = 0, epc = 0, cause_code = 0, exl = 0, redirect = 0, redirect_pc = 0, state = RUN.
- Reset asserted mid-operation clears everything immediately (asynchronous).
- Latency: ID decode → EX registered 1 cycle, then one stage per cycle.
- redirect asserts exactly 1 cycle, the cycle after the EX detection edge.
- stall = 1: all stage registers hold. During a stall, detection is evaluated only when stall = 0.
- flush_id = 1 with stall = 0: EX loads a bubble while later stages advance.
- Priority: trap/ERET squash > stall > flush_id > normal advance. A trap detected while stall is low overrides a simultaneous flush_id.
- An exception and an ERET cannot coexist in one EX bundle; an exception takes precedence.
- Back-to-back: the instruction following a redirect is evaluated normally in RUN.

## Structure
- Package `ctrl_pkg` holds:
  - opcode, funct, rt and rs constants;
  - ALUOP encodings and the Branch encodings;
  - EXC codes (NOT = 0, SYSCALL = 8, BREAK = 9, RI = 10);
  - the ctrl bundle struct and CTRL_W;
  - the FSM state enum.
- Sub-module `ctrl_decode` is the combinational instruction-to-bundle decoder. `ctrl_pipe` instantiates it and owns the stage registers, FSM and CP0 fields.

## Test plan
- ADDU (`0x00851021`), valid, no stall → stg_valid[0] with RegDst = 01 and RegWrite = 1 after 1 cycle; present in WB after 3 cycles.
- SYSCALL at pc 0x400 → 1 cycle later redirect = 1, redirect_pc = 0x80000180; epc = 0x400, cause_code = 8, exl = 1; EX and the following ID slot are invalid.
- With exl = 1, BREAK at 0x500 → epc stays 0x400, cause_code = 9, redirect to the vector.
- ERET (`0x42000018`) with epc = 0x400 → redirect_pc = 0x400 for 1 cycle, exl = 0.
- stall held 3 cycles with a LW in EX → all stages unchanged. A simultaneous stall and flush_id → hold wins; on release the flush inserts a bubble.
- Opcode 0x3F in EX → cause_code = 10, trap taken. Asserting rst_n = 0 during TRAP → all outputs 0 immediately.
